// File: rtl/ad4008_pkg.sv
// ---------------------------------------------------------------------------
// ad4008_pkg
// Shared definitions for the AD4008 serial-interface responder.
//   state_e           : responder FSM states
//   ADC_WIDTH_DEFAULT : default conversion word width
//   STATUS_BITS       : extra bits appended per frame when the status
//                       option (AD4008_RESPONDER_STATUS_EN) is built in
// ---------------------------------------------------------------------------
package ad4008_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StWaitLow,
        StShift
    } state_e;

    localparam int unsigned ADC_WIDTH_DEFAULT = 16;
    localparam int unsigned STATUS_BITS       = 2;

endpackage

// File: rtl/ad4008_responder_if.sv
// ---------------------------------------------------------------------------
// ad4008_responder_if
// Bundles the sample valid/ready port, the 3-wire ADC link and the status
// outputs of the AD4008 responder.
//   master : fabric + reader side (drives sample_data/valid, cnv, sck)
//   slave  : responder side (drives sample_ready, sdo, busy, pulses)
// ---------------------------------------------------------------------------
interface ad4008_responder_if #(
    parameter int unsigned ADC_WIDTH = 16
);
    logic [ADC_WIDTH-1:0] sample_data;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 cnv;
    logic                 sck;
    logic                 sdo;
    logic                 busy;
    logic                 stale_pulse;
    logic                 abort_pulse;

    modport master (
        output sample_data, sample_valid, cnv, sck,
        input  sample_ready, sdo, busy, stale_pulse, abort_pulse
    );

    modport slave (
        input  sample_data, sample_valid, cnv, sck,
        output sample_ready, sdo, busy, stale_pulse, abort_pulse
    );
endinterface

// File: rtl/ad4008_edge_sync.sv
// ---------------------------------------------------------------------------
// ad4008_edge_sync
// Multi-flop synchronizer for an asynchronous input plus one edge-detect
// register behind the last stage.
//   clk, aresetn : clock, async active-low reset
//   i_async      : asynchronous input
//   o_level      : synchronized level (last stage)
//   o_rise       : one-cycle pulse on a synchronized rising edge
//   o_fall       : one-cycle pulse on a synchronized falling edge
// ---------------------------------------------------------------------------
module ad4008_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic aresetn,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;
endmodule

// File: rtl/ad4008_responder.sv
// ---------------------------------------------------------------------------
// ad4008_responder
// Converter end of an AD4008 3-wire link (cnv, sck in; sdo out), serving
// words supplied by fabric through a one-entry valid/ready buffer. cnv and
// sck are oversampled by clk.
//   clk     : system clock
//   aresetn : asynchronous active-low reset
//   bus     : ad4008_responder_if.slave (sample port, cnv/sck/sdo, busy,
//             stale_pulse, abort_pulse)
// Build option: define AD4008_RESPONDER_STATUS_EN to append a stale bit and
// an even-parity bit after the data LSB of every frame.
// ---------------------------------------------------------------------------
module ad4008_responder
    import ad4008_pkg::*;
#(
    parameter int unsigned ADC_WIDTH   = ADC_WIDTH_DEFAULT,
    parameter int unsigned CONV_CYCLES = 15,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               aresetn,
    ad4008_responder_if.slave bus
);
`ifdef AD4008_RESPONDER_STATUS_EN
    localparam int unsigned FRAME_BITS = ADC_WIDTH + STATUS_BITS;
`else
    localparam int unsigned FRAME_BITS = ADC_WIDTH;
`endif
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int unsigned CONV_CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    // Synchronized inputs
    logic w_cnv_level, w_cnv_rise, w_cnv_fall;
    logic w_sck_level, w_sck_rise, w_sck_fall;
    logic w_unused_edges;

    ad4008_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnv_sync (
        .clk     (clk),
        .aresetn (aresetn),
        .i_async (bus.cnv),
        .o_level (w_cnv_level),
        .o_rise  (w_cnv_rise),
        .o_fall  (w_cnv_fall)
    );

    ad4008_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sck_sync (
        .clk     (clk),
        .aresetn (aresetn),
        .i_async (bus.sck),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // Only cnv level/rise and sck fall drive the protocol.
    assign w_unused_edges = ^{w_cnv_fall, w_sck_level, w_sck_rise};

    // State
    state_e                  r_state;
    logic [ADC_WIDTH-1:0]    r_word;
    logic                    r_fresh;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [CONV_CNT_W-1:0]   r_conv_cnt;
    logic                    r_sdo;
    logic                    r_busy;
    logic                    r_stale_pulse;
    logic                    r_abort_pulse;

    logic                    w_capture;
    logic                    w_handshake;
    logic [FRAME_BITS-1:0]   w_frame_word;

    // A new conversion may start from IDLE or by cutting a frame short.
    assign w_capture   = w_cnv_rise && ((r_state == StIdle) || (r_state == StShift));
    assign w_handshake = bus.sample_valid && bus.sample_ready;

`ifdef AD4008_RESPONDER_STATUS_EN
    // Stale bit is set when the buffer holds no fresh word at capture.
    assign w_frame_word = {r_word, ~r_fresh, ^r_word};
`else
    assign w_frame_word = r_word;
`endif

    // One-entry buffer; on a handshake/capture collision the capture takes
    // the old word (via w_frame_word) and the incoming word stays fresh.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_word  <= '0;
            r_fresh <= 1'b0;
        end else if (w_handshake) begin
            r_word  <= bus.sample_data;
            r_fresh <= 1'b1;
        end else if (w_capture) begin
            r_fresh <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= StIdle;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_conv_cnt    <= '0;
            r_sdo         <= 1'b0;
            r_busy        <= 1'b0;
            r_stale_pulse <= 1'b0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_stale_pulse <= 1'b0;
            r_abort_pulse <= 1'b0;
            if (w_capture) begin
                r_shift       <= w_frame_word;
                r_stale_pulse <= ~r_fresh;
                r_abort_pulse <= (r_state == StShift);
                r_conv_cnt    <= CONV_CNT_W'(CONV_CYCLES - 1);
                r_busy        <= 1'b1;
                r_sdo         <= 1'b0;
                r_state       <= StConvert;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_sdo <= 1'b0;
                    end
                    StConvert: begin
                        if (r_conv_cnt == '0) begin
                            r_busy <= 1'b0;
                            if (w_cnv_level) begin
                                r_state <= StWaitLow;
                            end else begin
                                r_sdo     <= r_shift[FRAME_BITS-1];
                                r_bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
                                r_state   <= StShift;
                            end
                        end else begin
                            r_conv_cnt <= r_conv_cnt - CONV_CNT_W'(1);
                        end
                    end
                    StWaitLow: begin
                        if (!w_cnv_level) begin
                            r_sdo     <= r_shift[FRAME_BITS-1];
                            r_bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
                            r_state   <= StShift;
                        end
                    end
                    StShift: begin
                        if (w_sck_fall) begin
                            if (r_bit_cnt == '0) begin
                                // Fall past the last bit ends the frame.
                                r_sdo   <= 1'b0;
                                r_state <= StIdle;
                            end else begin
                                r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                                r_sdo     <= r_shift[FRAME_BITS-2];
                                r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.sample_ready = ~r_fresh | w_capture;
    assign bus.sdo          = r_sdo;
    assign bus.busy         = r_busy;
    assign bus.stale_pulse  = r_stale_pulse;
    assign bus.abort_pulse  = r_abort_pulse;
endmodule

// File: tb/tb_ad4008_responder.sv
// ---------------------------------------------------------------------------
// tb_ad4008_responder
// Self-checking bench for ad4008_responder. The bench acts as both the
// fabric producer and the ADC reader; expected frames come from a small
// buffer model (last word + fresh flag).
// ---------------------------------------------------------------------------
module tb_ad4008_responder;
    localparam int unsigned W    = 16;
    localparam int unsigned CONV = 15;
    localparam int unsigned HALF = 6;
`ifdef AD4008_RESPONDER_STATUS_EN
    localparam int unsigned FRAME = W + 2;
`else
    localparam int unsigned FRAME = W;
`endif

    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    ad4008_responder_if #(.ADC_WIDTH(W)) bus ();

    ad4008_responder #(
        .ADC_WIDTH   (W),
        .CONV_CYCLES (CONV),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Event counters, sampled on the inactive edge.
    int stale_seen = 0;
    int abort_seen = 0;
    int busy_seen  = 0;
    always @(negedge clk) begin
        if (bus.stale_pulse === 1'b1) stale_seen <= stale_seen + 1;
        if (bus.abort_pulse === 1'b1) abort_seen <= abort_seen + 1;
        if (bus.busy === 1'b1)        busy_seen  <= busy_seen + 1;
    end

    // Reference model: what a reader should see for each conversion.
    logic [W-1:0] m_word  = '0;
    bit           m_fresh = 1'b0;

    function automatic logic [FRAME-1:0] model_frame(input logic [W-1:0] w, input bit stale);
        int ones = 0;
        for (int i = 0; i < int'(W); i++) ones += int'(w[i]);
`ifdef AD4008_RESPONDER_STATUS_EN
        return {w, stale, 1'(ones % 2)};
`else
        return FRAME'(w) | FRAME'(stale & 1'b0) | FRAME'(ones & 0);
`endif
    endfunction

    task automatic m_capture(output logic [FRAME-1:0] exp, output bit stale);
        stale   = !m_fresh;
        exp     = model_frame(m_word, stale);
        m_fresh = 1'b0;
    endtask

    // Producer: offer a word and wait (bounded) for the handshake.
    task automatic load_word(input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        bus.sample_data  = d;
        bus.sample_valid = 1'b1;
        while (bus.sample_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        chk_cnt++;
        if (n >= 200) $display("FAIL load_timeout ready=%b required=1", bus.sample_ready);
        else begin
            pass_cnt++;
            m_word  = d;
            m_fresh = 1'b1;
        end
    endtask

    task automatic start_conv();
        @(negedge clk);
        bus.cnv = 1'b1;
        repeat (20) @(negedge clk);
        bus.cnv = 1'b0;
    endtask

    // Reader: sample a bit, then clock one sck fall; n bits in total.
    task automatic read_bits(input int n, output logic [FRAME-1:0] got);
        got = '0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            got = {got[FRAME-2:0], bus.sdo};
            bus.sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic run_frame(output logic [FRAME-1:0] got);
        start_conv();
        read_bits(FRAME, got);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.cnv = 1'($urandom_range(0, 1));
            bus.sck = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_cnt++;
            if ({bus.sdo, bus.busy, bus.sample_ready} !== 3'b001)
                $display("FAIL reset_outputs sdo/busy/ready=%b required=001",
                         {bus.sdo, bus.busy, bus.sample_ready});
            else pass_cnt++;
        end
        bus.cnv = 1'b0;
        bus.sck = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        m_word  = '0;
        m_fresh = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++;
        if (stale_seen !== 0 || abort_seen !== 0 || bus.sdo !== 1'b0)
            $display("FAIL idle_after_reset stale=%0d abort=%0d sdo=%b required=0/0/0",
                     stale_seen, abort_seen, bus.sdo);
        else pass_cnt++;
    endtask

    task automatic test_basic(input logic [W-1:0] d);
        logic [FRAME-1:0] exp, got;
        bit st;
        int s0, b0;
        load_word(d);
        s0 = stale_seen;
        b0 = busy_seen;
        m_capture(exp, st);
        run_frame(got);
        chk_cnt++;
        if (got !== exp) $display("FAIL basic_data got=%h required=%h", got, exp);
        else pass_cnt++;
        chk_cnt++;
        if (busy_seen - b0 !== int'(CONV))
            $display("FAIL basic_busy_cycles got=%0d required=%0d", busy_seen - b0, CONV);
        else pass_cnt++;
        chk_cnt++;
        if (stale_seen - s0 !== 0) $display("FAIL basic_stale got=%0d required=0", stale_seen - s0);
        else pass_cnt++;
    endtask

    task automatic test_stale_reuse();
        logic [FRAME-1:0] exp, got;
        bit st;
        int s0;
        load_word(16'h1234);
        s0 = stale_seen;
        m_capture(exp, st);
        run_frame(got);
        chk_cnt++;
        if (got !== exp || got[FRAME-1 -: W] !== 16'h1234)
            $display("FAIL stale_frame1 got=%h required=%h", got, exp);
        else pass_cnt++;
        chk_cnt++;
        if (stale_seen - s0 !== 0) $display("FAIL stale_first got=%0d required=0", stale_seen - s0);
        else pass_cnt++;
        m_capture(exp, st);
        run_frame(got);
        chk_cnt++;
        if (got !== exp || got[FRAME-1 -: W] !== 16'h1234)
            $display("FAIL stale_frame2 got=%h required=%h", got, exp);
        else pass_cnt++;
        chk_cnt++;
        if (stale_seen - s0 !== 1) $display("FAIL stale_second got=%0d required=1", stale_seen - s0);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [FRAME-1:0] exp1, exp2, got;
        bit st;
        int s0, n;
        load_word(16'h1111);
        s0 = stale_seen;
        @(negedge clk);
        bus.sample_data  = 16'h5555;
        bus.sample_valid = 1'b1;
        chk_cnt++;
        if (bus.sample_ready !== 1'b0) $display("FAIL collide_full_ready got=%b required=0",
                                                bus.sample_ready);
        else pass_cnt++;
        // Ready only opens on the capture cycle, so the handshake lands there.
        bus.cnv = 1'b1;
        n = 0;
        while (bus.busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.sample_valid = 1'b0;
        m_capture(exp1, st);
        m_word  = 16'h5555;
        m_fresh = 1'b1;
        chk_cnt++;
        if (n >= 20) $display("FAIL collide_busy_timeout busy=%b required=1", bus.busy);
        else pass_cnt++;
        repeat (20) @(negedge clk);
        bus.cnv = 1'b0;
        read_bits(FRAME, got);
        chk_cnt++;
        if (got !== exp1) $display("FAIL collide_frame1 got=%h required=%h", got, exp1);
        else pass_cnt++;
        m_capture(exp2, st);
        run_frame(got);
        chk_cnt++;
        if (got !== exp2) $display("FAIL collide_frame2 got=%h required=%h", got, exp2);
        else pass_cnt++;
        chk_cnt++;
        if (stale_seen - s0 !== 0) $display("FAIL collide_stale got=%0d required=0", stale_seen - s0);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [FRAME-1:0] exp1, exp2, got;
        bit st;
        int a0;
        load_word(16'hFFFF);
        a0 = abort_seen;
        m_capture(exp1, st);
        start_conv();
        load_word(16'h0001);
        read_bits(5, got);
        chk_cnt++;
        if (got[4:0] !== exp1[FRAME-1 -: 5])
            $display("FAIL abort_partial got=%b required=%b", got[4:0], exp1[FRAME-1 -: 5]);
        else pass_cnt++;
        m_capture(exp2, st);
        run_frame(got);
        chk_cnt++;
        if (abort_seen - a0 !== 1) $display("FAIL abort_pulse got=%0d required=1", abort_seen - a0);
        else pass_cnt++;
        chk_cnt++;
        if (got !== exp2) $display("FAIL abort_frame2 got=%h required=%h", got, exp2);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [FRAME-1:0] exp, got;
        bit st;
        int s0;
        load_word(16'hABCD);
        start_conv();
        read_bits(3, got);
        aresetn = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({bus.sdo, bus.busy, bus.sample_ready} !== 3'b001)
            $display("FAIL midreset_outputs sdo/busy/ready=%b required=001",
                     {bus.sdo, bus.busy, bus.sample_ready});
        else pass_cnt++;
        aresetn = 1'b1;
        m_word  = '0;
        m_fresh = 1'b0;
        repeat (4) @(negedge clk);
        s0 = stale_seen;
        m_capture(exp, st);
        run_frame(got);
        chk_cnt++;
        if (got !== exp) $display("FAIL midreset_frame got=%h required=%h", got, exp);
        else pass_cnt++;
        chk_cnt++;
        if (stale_seen - s0 !== 1) $display("FAIL midreset_stale got=%0d required=1", stale_seen - s0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [FRAME-1:0] exp, got;
        bit st;
        int s0;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 2) != 0) load_word(W'($urandom));
            s0 = stale_seen;
            m_capture(exp, st);
            run_frame(got);
            chk_cnt++;
            if (got !== exp) $display("FAIL random_frame%0d got=%h required=%h", i, got, exp);
            else pass_cnt++;
            chk_cnt++;
            if (stale_seen - s0 !== int'(st))
                $display("FAIL random_stale%0d got=%0d required=%0d", i, stale_seen - s0, st);
            else pass_cnt++;
        end
    endtask

`ifdef AD4008_RESPONDER_STATUS_EN
    task automatic test_status();
        logic [FRAME-1:0] exp, got;
        logic [17:0] want;
        bit st;
        want = 18'b0000000000000011_1_0;
        load_word(16'h0003);
        m_capture(exp, st);
        run_frame(got);
        m_capture(exp, st);
        run_frame(got);
        chk_cnt++;
        if (got !== want) $display("FAIL status_frame got=%b required=%b", got, want);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.sample_data  = '0;
        bus.sample_valid = 1'b0;
        bus.cnv          = 1'b0;
        bus.sck          = 1'b0;
        test_reset();
        test_basic(16'hAAAA);
        test_basic(16'h00F0);
        test_stale_reuse();
        test_collision();
        test_abort();
        test_reset_midframe();
        test_random();
`ifdef AD4008_RESPONDER_STATUS_EN
        test_status();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ad4008_responder.md
Name: ad4008_responder

Overview:
- Synthesizable, clk-domain responder for the AD4008 3-wire serial interface: the converter end of the link driven by the ADC read block (cnv, sck in; sdo out).
- Serves 16-bit sample words supplied by fabric logic through a valid/ready port.
- Used for on-FPGA loopback of the ADC read path and for hardware-in-the-loop data injection without a physical ADC.
- cnv and sck are treated as asynchronous inputs and oversampled by clk.

Parameters:
- ADC_WIDTH, 16, bits per conversion word, shifted MSB first.
- CONV_CYCLES, 15, clk cycles of emulated conversion time (tCONV) after a detected cnv rising edge; minimum 1.
- SYNC_STAGES, 2, flip-flop stages on the cnv and sck inputs; minimum 2.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- aresetn  in  1  asynchronous, active-low reset.
- sample_data  in  ADC_WIDTH  next word to serve.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  one-entry buffer can accept a word.
- cnv  in  1  conversion start / frame select from the reader.
- sck  in  1  serial clock from the reader.
- sdo  out  1  serial data to the reader.
- busy  out  1  high in CONVERT.
- stale_pulse  out  1  one-cycle pulse: a conversion started with no fresh word.
- abort_pulse  out  1  one-cycle pulse: a frame was cut short by a new cnv rise.

Behaviour:
- Reset values: sdo=0, busy=0, stale_pulse=0, abort_pulse=0, sample_ready=1, buffer empty, buffer word=0, state IDLE, synchronizers cleared to 0.
- Inputs: cnv and sck each pass through SYNC_STAGES flops. Edge detect compares the last synchronized stage with one extra register.
- Buffer: word register plus a fresh flag.
  - sample_ready = !fresh || capture, where capture is the cycle a conversion starts.
  - A handshake (valid && ready) loads the word and sets fresh.
  - If a handshake and a capture coincide: the capture takes the old word and the incoming word becomes fresh.
- FSM states: IDLE, CONVERT, WAIT_LOW, SHIFT.
- IDLE:
  - sdo=0.
  - On a synced cnv rising edge: shift_reg <= buffer word; clear fresh; pulse stale_pulse if fresh was 0 (the last word is reused; 0 after reset); counter <= CONV_CYCLES-1; go to CONVERT.
- CONVERT:
  - busy=1; the counter decrements each cycle.
  - At 0: go to WAIT_LOW if cnv_sync=1, else go directly to SHIFT.
- WAIT_LOW: on cnv_sync=0, go to SHIFT.
- SHIFT:
  - On entry, sdo = shift_reg MSB; bit counter = ADC_WIDTH-1.
  - Each synced sck falling edge shifts left and presents the next bit.
  - The falling edge that would advance past the LSB sets sdo=0 and returns to IDLE.
  - sck rising edges are ignored.
- Latency: sdo is valid SYNC_STAGES+2 clk cycles after a physical cnv fall or sck fall. Reader requirement: sck half-period ≥ SYNC_STAGES+3 clk cycles.
- cnv rising in CONVERT or WAIT_LOW: ignored; conversion is not restarted.
- cnv rising in SHIFT:
  - Pulse abort_pulse.
  - Start a new conversion exactly as from IDLE, in the same cycle.
  - The remaining bits of the aborted frame are discarded.
- sck edges outside SHIFT are ignored.
- aresetn assertion mid-frame: everything returns immediately to reset values; the buffered word is lost.

Optional Feature:
- Macro: AD4008_RESPONDER_STATUS_EN.
- Defined: after the LSB, two extra bits are shifted on further sck falls:
  - stale bit (1 if this frame reused a word);
  - even parity over the ADC_WIDTH data bits.
  - The frame is ADC_WIDTH+2 bits; the return to IDLE follows the last status bit.
- Undefined: the frame is exactly ADC_WIDTH bits and there is no extra logic.

Decomposition:
- Shared package ad4008_pkg:
  - state enum (IDLE, CONVERT, WAIT_LOW, SHIFT);
  - ADC_WIDTH default constant;
  - STATUS_BITS=2 constant.
- One sub-module: ad4008_edge_sync. It holds the SYNC_STAGES synchronizer plus edge-detect register and outputs level, rise and fall; it is instanced for cnv and for sck.

Test Plan:
- Reset then idle: hold aresetn=0 with random cnv/sck activity -> sdo=0, busy=0, sample_ready=1 throughout; after release no pulses fire.
- Basic frame:
  - Stimulus: load 16'hAAAA; cnv high 20 cycles then low; 16 sck falls at half-period 6.
  - Response: busy high for exactly 15 cycles; reader captures 16'hAAAA; stale_pulse never fires.
  - Repeat with 16'h00F0.
- Stale reuse: load 16'h1234 and complete two frames without reloading -> both frames read 16'h1234; stale_pulse fires once, at the second cnv rise.
- Buffer handshake collision: present 16'h5555 valid on the exact capture cycle while 16'h1111 is buffered -> frame 1 reads 16'h1111, frame 2 reads 16'h5555, no stale_pulse.
- Abort: load 16'hFFFF then 16'h0001; raise cnv after 5 sck falls of frame 1 -> abort_pulse once; frame 2 reads 16'h0001 complete.
- With AD4008_RESPONDER_STATUS_EN: second stale frame of 16'h0003 -> 18 bits received, 0000000000000011_1_0 (stale=1, parity=0).
